test_scheduler: RTL and testbench

- Serialises the production-test launches (flash memtest, SRAM memtest, SD, flash, mouse) requested by the keyboard mode decoder, so that only one test owns the shared hardware at a time.
- Queues request pulses, starts one test, waits for its done/ok or a timeout, and records a per-test pass/fail/timeout result.
- Sits between the keyboard decoder pulses and the test engines; a backspace/return-to-BIOS pulse aborts everything.

---
 rtl/test_scheduler.sv | 98 +++++++++
 tb/tb_test_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_scheduler.sv
// test_scheduler: queues production-test requests and runs one test at a time,
// recording a sticky pass/fail/timeout result per test.
module test_scheduler #(
  parameter int NTEST = 5,
  parameter int CNT_W = 26,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NTEST-1:0] req,
  input  logic             abort,
  input  logic [NTEST-1:0] test_done,
  input  logic [NTEST-1:0] test_ok,
  output logic [NTEST-1:0] test_start,
  output logic             test_abort,
  output logic             busy,
  output logic [2:0]       active,
  output logic [NTEST-1:0] pending,
  output logic [NTEST-1:0] res_pass,
  output logic [NTEST-1:0] res_fail,
  output logic [NTEST-1:0] res_tout,
  output logic             result_stb
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, RUN = 2'd2, REPORT = 2'd3;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] first;
  logic [NTEST-1:0] grant, own;
  always_comb begin
    first = '0;
    for (int i = NTEST - 1; i >= 0; i--) if (pending[i]) first = 3'(i);
    grant = (state == IDLE && |pending) ? NTEST'(1) << first : '0;
    own = (state != IDLE) ? NTEST'(1) << active : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      test_start <= '0;
      test_abort <= 1'b0;
      busy <= 1'b0;
      active <= '0;
      pending <= '0;
      res_pass <= '0;
      res_fail <= '0;
      res_tout <= '0;
      result_stb <= 1'b0;
    end else begin
      test_start <= '0;
      test_abort <= 1'b0;
      result_stb <= 1'b0;
      if (abort) begin
        pending <= '0;
        state <= IDLE;
        busy <= 1'b0;
        active <= '0;
        test_abort <= (state == START || state == RUN);
      end else begin
        // requests for the test that currently owns the hardware are dropped
        pending <= (pending | (req & ~own)) & ~grant;
        case (state)
          IDLE: if (|pending) begin
            state <= START;
            busy <= 1'b1;
            active <= first;
            test_start <= grant;
            cnt <= '0;
          end
          START: begin
            res_pass <= res_pass & ~own;
            res_fail <= res_fail & ~own;
            res_tout <= res_tout & ~own;
            cnt <= cnt + 1'b1;
            state <= RUN;
          end
          RUN: begin
            cnt <= cnt + 1'b1;
            if (|(test_done & own)) begin
              res_pass <= res_pass | (own & test_ok);
              res_fail <= res_fail | (own & ~test_ok);
              result_stb <= 1'b1;
              state <= REPORT;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              res_tout <= res_tout | own;
              result_stb <= 1'b1;
              state <= REPORT;
            end
          end
          default: begin
            state <= IDLE;
            busy <= 1'b0;
            active <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_test_scheduler.sv
// tb_test_scheduler: directed scenarios plus a randomized run against a
// timestamp-based reference model of the scheduler.
module tb_test_scheduler;
  localparam int T = 16;
  logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0;
  logic [4:0] req = '0, test_done = '0, test_ok = '0;
  logic [4:0] test_start, pending, res_pass, res_fail, res_tout;
  logic test_abort, busy, result_stb;
  logic [2:0] active;
  int total = 0, passed = 0, stb_cnt = 0;

  test_scheduler #(.NTEST(5), .CNT_W(26), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .abort(abort), .test_done(test_done),
    .test_ok(test_ok), .test_start(test_start), .test_abort(test_abort),
    .busy(busy), .active(active), .pending(pending), .res_pass(res_pass),
    .res_fail(res_fail), .res_tout(res_tout), .result_stb(result_stb)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && result_stb) stb_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    abort = 1'b0;
    test_done = '0;
    test_ok = '0;
    tick;
    tick;
    rst_n = 1'b1;
    stb_cnt = 0;
  endtask

  task automatic wait_start(output bit got, output logic [4:0] which);
    got = 0;
    which = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (test_start != 0) begin
        got = 1;
        which = test_start;
      end else tick;
    end
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({test_start, test_abort, busy, active, pending, res_pass, res_fail, res_tout, result_stb} !== 31'd0)
        $display("FAIL reset cyc%0d outputs=%h want 0", i,
                 {test_start, test_abort, busy, active, pending, res_pass, res_fail, res_tout, result_stb});
      else passed++;
      tick;
    end
  endtask

  task automatic test_single_pass;
    do_reset;
    req = 5'b00001;
    tick;
    req = '0;
    total++;
    if ({test_start, busy, pending} !== {5'b0, 1'b0, 5'b00001})
      $display("FAIL single_cyc1 got=%b want=%b", {test_start, busy, pending}, {5'b0, 1'b0, 5'b00001});
    else passed++;
    tick;
    for (int c = 2; c <= 10; c++) begin
      total++;
      if ({test_start, busy, active, result_stb} !== {((c == 2) ? 5'b00001 : 5'b0), 1'b1, 3'd0, 1'b0})
        $display("FAIL single_cyc%0d got=%b want start=%b busy=1", c,
                 {test_start, busy, active, result_stb}, (c == 2) ? 5'b00001 : 5'b0);
      else passed++;
      if (c == 10) begin
        test_done = 5'b00001;
        test_ok = 5'b00001;
      end
      tick;
    end
    test_done = '0;
    test_ok = '0;
    total++;
    if ({busy, res_pass, res_fail, res_tout, result_stb, pending} !== {1'b1, 5'b00001, 10'b0, 1'b1, 5'b0})
      $display("FAIL single_report got=%b want=%b", {busy, res_pass, res_fail, res_tout, result_stb, pending},
               {1'b1, 5'b00001, 10'b0, 1'b1, 5'b0});
    else passed++;
    tick;
    total++;
    if ({busy, result_stb, res_pass} !== {1'b0, 1'b0, 5'b00001})
      $display("FAIL single_after got=%b want=%b", {busy, result_stb, res_pass}, {1'b0, 1'b0, 5'b00001});
    else passed++;
  endtask

  task automatic test_priority;
    bit got;
    logic [4:0] which, exp;
    do_reset;
    req = 5'b10100;
    tick;
    req = '0;
    for (int k = 0; k < 2; k++) begin
      exp = k == 0 ? 5'b00100 : 5'b10000;
      wait_start(got, which);
      total++;
      if (!got || which !== exp || active !== (k == 0 ? 3'd2 : 3'd4))
        $display("FAIL prio_start%0d got=%b active=%0d want=%b", k, which, active, exp);
      else passed++;
      repeat (3) tick;
      test_done = exp;
      test_ok = '0;
      tick;
      test_done = '0;
    end
    repeat (4) tick;
    total++;
    if ({res_fail, res_pass, busy} !== {5'b10100, 5'b0, 1'b0} || stb_cnt != 2)
      $display("FAIL prio_final res_fail=%b res_pass=%b busy=%b stb=%0d want 10100/00000/0/2",
               res_fail, res_pass, busy, stb_cnt);
    else passed++;
  endtask

  task automatic test_timeout;
    bit got;
    logic [4:0] which;
    do_reset;
    req = 5'b01000;
    tick;
    req = '0;
    wait_start(got, which);
    total++;
    if (!got || which !== 5'b01000) $display("FAIL tout_start got=%b want 01000", which);
    else passed++;
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) test_done = 5'b00001;
      tick;
      test_done = '0;
      total++;
      if ({res_tout, res_pass, res_fail, result_stb} !== {((k == 16) ? 5'b01000 : 5'b0), 10'b0, k == 16})
        $display("FAIL tout_k%0d got tout=%b pass=%b fail=%b stb=%b want tout=%b", k,
                 res_tout, res_pass, res_fail, result_stb, (k == 16) ? 5'b01000 : 5'b0);
      else passed++;
    end
  endtask

  task automatic test_abort_mid_run;
    bit got;
    logic [4:0] which;
    int starts;
    do_reset;
    req = 5'b00011;
    tick;
    req = '0;
    wait_start(got, which);
    repeat (5) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if ({test_abort, pending, busy, active} !== {1'b1, 5'b0, 1'b0, 3'd0})
      $display("FAIL abort_next got=%b want=%b", {test_abort, pending, busy, active}, {1'b1, 9'b0});
    else passed++;
    tick;
    starts = 0;
    total++;
    if (test_abort !== 1'b0) $display("FAIL abort_pulse test_abort=%b want 0", test_abort);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      if (test_start != 0) starts++;
      tick;
    end
    total++;
    if (starts != 0 || {res_pass, res_fail, res_tout} !== 15'b0)
      $display("FAIL abort_after starts=%0d res=%b want 0", starts, {res_pass, res_fail, res_tout});
    else passed++;
  endtask

  task automatic test_dup_simul;
    bit got;
    logic [4:0] which;
    int s0, s1;
    do_reset;
    req = 5'b00001;
    tick;
    req = '0;
    wait_start(got, which);
    tick;
    req = 5'b00011;
    tick;
    req = '0;
    total++;
    if (pending !== 5'b00010) $display("FAIL dup_pend1 got=%b want 00010", pending);
    else passed++;
    req = 5'b00010;
    tick;
    req = '0;
    total++;
    if (pending !== 5'b00010) $display("FAIL dup_pend2 got=%b want 00010", pending);
    else passed++;
    repeat (12) tick;
    test_done = 5'b00001;
    test_ok = 5'b00001;
    tick;
    test_done = '0;
    test_ok = '0;
    total++;
    if ({res_pass, res_tout, result_stb} !== {5'b00001, 5'b0, 1'b1})
      $display("FAIL dup_simul pass=%b tout=%b stb=%b want 00001/00000/1", res_pass, res_tout, result_stb);
    else passed++;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (test_start[0]) s0++;
      if (test_start[1]) s1++;
      tick;
    end
    total++;
    if (s0 != 0 || s1 != 1 || res_tout !== 5'b00010)
      $display("FAIL dup_runs s0=%0d s1=%0d tout=%b want 0/1/00010", s0, s1, res_tout);
    else passed++;
  endtask

  task automatic test_async_reset;
    bit got;
    logic [4:0] which;
    do_reset;
    req = 5'b00110;
    tick;
    req = '0;
    wait_start(got, which);
    repeat (3) tick;
    total++;
    if ({busy, pending} !== {1'b1, 5'b00100}) $display("FAIL areset_pre busy=%b pending=%b want 1/00100", busy, pending);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({test_start, test_abort, busy, active, pending, res_pass, res_fail, res_tout, result_stb} !== 31'd0)
      $display("FAIL areset_drop outputs=%h want 0",
               {test_start, test_abort, busy, active, pending, res_pass, res_fail, res_tout, result_stb});
    else passed++;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({busy, pending, test_start} !== 11'b0)
        $display("FAIL areset_idle%0d busy=%b pending=%b start=%b want 0", i, busy, pending, test_start);
      else passed++;
    end
  endtask

  task automatic test_random;
    bit [4:0] q, rp, rf, rt, own;
    int job, t0, te;
    bit tab;
    logic [30:0] exp, got;
    do_reset;
    q = '0; rp = '0; rf = '0; rt = '0;
    job = -1; t0 = 0; te = -1; tab = 0;
    for (int c = 0; c < 1500; c++) begin
      exp = {(job >= 0 && c == t0) ? 5'(1 << job) : 5'b0, tab, job >= 0,
             job >= 0 ? 3'(job) : 3'd0, q, rp, rf, rt, c == te};
      got = {test_start, test_abort, busy, active, pending, res_pass, res_fail, res_tout, result_stb};
      total++;
      if (got !== exp) $display("FAIL random cyc%0d got=%b want=%b", c, got, exp);
      else passed++;
      req = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
      abort = ($urandom_range(0, 80) == 0);
      test_done = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b0;
      test_ok = 5'($urandom);
      tab = 0;
      if (abort) begin
        tab = job >= 0 && te < 0;
        q = '0;
        job = -1;
        te = -1;
      end else if (job < 0) begin
        if (q != 0) begin
          int l;
          l = 0;
          while (!q[l]) l++;
          q = (q | req) & ~(5'(1) << l);
          job = l;
          t0 = c + 1;
          te = -1;
        end else q = q | req;
      end else begin
        own = 5'(1 << job);
        if (c == t0) begin
          rp[job] = 0; rf[job] = 0; rt[job] = 0;
        end else if (te < 0) begin
          if (test_done[job]) begin
            rp[job] = test_ok[job];
            rf[job] = !test_ok[job];
            te = c + 1;
          end else if (c - t0 == T - 1) begin
            rt[job] = 1;
            te = c + 1;
          end
        end else job = -1;
        q = q | (req & ~own);
      end
      tick;
    end
    req = '0;
    abort = 1'b0;
    test_done = '0;
    test_ok = '0;
  endtask

  initial begin
    test_reset;
    test_single_pass;
    test_priority;
    test_timeout;
    test_abort_mid_run;
    test_dup_simul;
    test_async_reset;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
